// File: rtl/key_pkg.sv
// Shared types and default constants for the key debounce array.
// The optional auto-repeat is enabled by defining KEY_DEBOUNCE_REPEAT_EN.
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHECK,
    PRESSED,
    RELEASE_CHECK
  } key_state_t;

  localparam int DEF_STABLE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY  = 500000;
  localparam int DEF_REPEAT_PERIOD = 100000;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One debounced key: 2-flop synchroniser, stability counter and check FSM.
// With KEY_DEBOUNCE_REPEAT_EN defined, a held key also emits repeat press pulses.
module key_debounce_channel
  import key_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  localparam logic IDLE_RAW = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic [1:0]    sync;
  logic          s;
  key_state_t    state, state_next;
  logic [CW-1:0] count, count_next;
  logic          level_next, press_next, release_next;
  logic          repeat_fire;

  // Synchroniser resets to the released raw value so a held key looks like a fresh press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync <= {2{IDLE_RAW}};
    else       sync <= {sync[0], raw};
  end

  assign s = sync[1] ^ IDLE_RAW;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= RELEASED;
      count         <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      count         <= count_next;
      level         <= level_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
    end
  end

  always_comb begin
    state_next   = state;
    count_next   = count;
    level_next   = level;
    press_next   = 1'b0;
    release_next = 1'b0;
    unique case (state)
      RELEASED: begin
        if (s) begin
          state_next = PRESS_CHECK;
          count_next = CW'(1);
        end
      end
      PRESS_CHECK: begin
        if (!s) begin
          state_next = RELEASED;
          count_next = '0;
        end else if (count == LAST) begin
          state_next = PRESSED;
          count_next = '0;
          level_next = 1'b1;
          press_next = 1'b1;
        end else begin
          count_next = count + CW'(1);
        end
      end
      PRESSED: begin
        press_next = repeat_fire;
        if (!s) begin
          state_next = RELEASE_CHECK;
          count_next = CW'(1);
        end
      end
      RELEASE_CHECK: begin
        if (s) begin
          state_next = PRESSED;
          count_next = '0;
        end else if (count == LAST) begin
          state_next   = RELEASED;
          count_next   = '0;
          level_next   = 1'b0;
          release_next = 1'b1;
        end else begin
          count_next = count + CW'(1);
        end
      end
      default: begin
        state_next = RELEASED;
        count_next = '0;
      end
    endcase
  end

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_armed;
  logic [RW-1:0] rep_target;

  // The first repeat waits REPEAT_DELAY cycles, later ones REPEAT_PERIOD.
  assign rep_target  = rep_armed ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
  assign repeat_fire = (state == PRESSED) && (rep_cnt == rep_target);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (state == PRESSED) begin
      if (repeat_fire) begin
        rep_cnt   <= '0;
        rep_armed <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + RW'(1);
      end
    end else if (state == RELEASE_CHECK && state_next != RELEASED) begin
      rep_cnt   <= rep_cnt;
      rep_armed <= rep_armed;
    end else begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_array.sv
// NUM_KEYS independent debounced key channels plus an any-key-held flag.
// Define KEY_DEBOUNCE_REPEAT_EN to enable auto-repeat press pulses.
module key_debounce_array
  import key_pkg::*;
#(
  parameter int NUM_KEYS      = 4,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                any_pressed
);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_channel (
      .clock        (clock),
      .reset        (reset),
      .raw          (key_in[k]),
      .level        (key_level[k]),
      .press_pulse  (key_press[k]),
      .release_pulse(key_release[k])
    );
  end

  assign any_pressed = |key_level;

endmodule

// File: tb/tb_key_debounce_array.sv
// Self-checking bench for key_debounce_array: directed scenarios plus randomized key bouncing,
// all compared against a run-length reference model of the debounce rules.
module tb_key_debounce_array;

  localparam int NK = 4;
  localparam int SC = 4;
  localparam int RD = 10;
  localparam int RP = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [NK-1:0] key_in = '1;
  logic [NK-1:0] key_level, key_press, key_release;
  logic          any_pressed;

  int n_cmp = 0;
  int n_bad = 0;

  key_debounce_array #(
    .NUM_KEYS(NK), .STABLE_CYCLES(SC), .ACTIVE_LOW(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clock(clock), .reset(reset), .key_in(key_in),
    .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .any_pressed(any_pressed)
  );

  always #5 clock = ~clock;

  // Reference model: a level flips once SC consecutive synchronised samples disagree with it;
  // repeats count held-and-not-checking cycles since the press.
  typedef struct packed {
    logic lv;
    logic pr;
    logic rl;
    int   r;
    int   el;
  } ch_t;

  logic [NK-1:0] p1, p2, exp_level, exp_press, exp_release;
  int            run [NK];
  int            elapsed [NK];
  ch_t           step_out [NK];

  function automatic ch_t ref_step(input logic s, input logic lv, input int r, input int el);
    ch_t o;
    o.lv = lv; o.pr = 1'b0; o.rl = 1'b0; o.r = r; o.el = el;
`ifdef KEY_DEBOUNCE_REPEAT_EN
    if (lv && r == 0) begin
      o.el = el + 1;
      if (o.el == RD || (o.el > RD && (o.el - RD) % RP == 0)) o.pr = 1'b1;
    end
`endif
    o.r = (s != lv) ? r + 1 : 0;
    if (o.r == SC) begin
      o.r  = 0;
      o.lv = ~lv;
      if (o.lv) begin
        o.pr = 1'b1;
        o.el = 0;
      end else begin
        o.rl = 1'b1;
      end
    end
    return o;
  endfunction

  always_comb begin
    for (int i = 0; i < NK; i++) step_out[i] = ref_step(p2[i], exp_level[i], run[i], elapsed[i]);
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      p1 <= '0; p2 <= '0;
      exp_level <= '0; exp_press <= '0; exp_release <= '0;
      for (int i = 0; i < NK; i++) begin
        run[i]     <= 0;
        elapsed[i] <= 0;
      end
    end else begin
      p2 <= p1;
      p1 <= ~key_in;
      for (int i = 0; i < NK; i++) begin
        exp_level[i]   <= step_out[i].lv;
        exp_press[i]   <= step_out[i].pr;
        exp_release[i] <= step_out[i].rl;
        run[i]         <= step_out[i].r;
        elapsed[i]     <= step_out[i].el;
      end
    end
  end

  wire [3*NK:0] obs  = {key_level, key_press, key_release, any_pressed};
  wire [3*NK:0] expv = {exp_level, exp_press, exp_release, |exp_level};

  task automatic test_reset();
    #1 reset = 1'b1;
    key_in = '1;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (obs !== '0) begin n_bad++; $display("[TB] FAIL reset_outputs got %b want 0", obs); end
    key_in = '0;
    @(negedge clock);
    n_cmp++;
    if (obs !== '0) begin n_bad++; $display("[TB] FAIL reset_hold_keys got %b want 0", obs); end
    key_in = '1;
    reset = 1'b0;
    for (int c = 0; c < SC + 4; c++) begin
      @(negedge clock);
      n_cmp++;
      if (obs !== expv) begin n_bad++; $display("[TB] FAIL reset_idle c=%0d got %b want %b", c, obs, expv); end
    end
  endtask

  task automatic test_clean_press();
    key_in = 4'b1110;
    for (int e = 0; e < 8; e++) begin
      @(negedge clock);
      n_cmp++;
      if (obs !== expv) begin n_bad++; $display("[TB] FAIL press_model e=%0d got %b want %b", e, obs, expv); end
      if (e == 4) begin
        n_cmp++;
        if (key_level[0] !== 1'b0) begin n_bad++; $display("[TB] FAIL press_early e=4 level=%b want 0", key_level[0]); end
      end
      if (e == 5) begin
        n_cmp++;
        if ({key_level[0], key_press[0]} !== 2'b11) begin
          n_bad++; $display("[TB] FAIL press_edge5 level/press=%b want 11", {key_level[0], key_press[0]});
        end
      end
      if (e == 6) begin
        n_cmp++;
        if ({key_press[0], any_pressed} !== 2'b01) begin
          n_bad++; $display("[TB] FAIL press_edge6 press/any=%b want 01", {key_press[0], any_pressed});
        end
      end
    end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    logic [13:0] pattern = 14'b00000000001000;
    for (int c = 0; c < 14; c++) begin
      key_in[1] = pattern[c];
      @(negedge clock);
      pulses += int'(key_press[1]);
      n_cmp++;
      if (obs !== expv) begin n_bad++; $display("[TB] FAIL bounce_model c=%0d got %b want %b", c, obs, expv); end
    end
    n_cmp++;
    if (pulses != 1) begin n_bad++; $display("[TB] FAIL bounce_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_release();
    key_in = '1;
    for (int e = 0; e < 8; e++) begin
      @(negedge clock);
      n_cmp++;
      if (obs !== expv) begin n_bad++; $display("[TB] FAIL release_model e=%0d got %b want %b", e, obs, expv); end
      if (e == 5) begin
        n_cmp++;
        if ({key_release[0], key_level[0], key_press[0]} !== 3'b100) begin
          n_bad++; $display("[TB] FAIL release_edge5 rel/lvl/press=%b want 100", {key_release[0], key_level[0], key_press[0]});
        end
      end
      if (e == 6) begin
        n_cmp++;
        if ({key_release[0], any_pressed} !== 2'b00) begin
          n_bad++; $display("[TB] FAIL release_edge6 rel/any=%b want 00", {key_release[0], any_pressed});
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    key_in = 4'b0000;
    for (int e = 0; e < 8; e++) begin
      @(negedge clock);
      n_cmp++;
      if (obs !== expv) begin n_bad++; $display("[TB] FAIL simul_model e=%0d got %b want %b", e, obs, expv); end
      if (e == 5 || e == 6) begin
        n_cmp++;
        if (key_press !== ((e == 5) ? 4'b1111 : 4'b0000)) begin
          n_bad++; $display("[TB] FAIL simul_press e=%0d got %b want %b", e, key_press, (e == 5) ? 4'b1111 : 4'b0000);
        end
      end
    end
    key_in = '1;
    for (int c = 0; c < SC + 4; c++) begin
      @(negedge clock);
      n_cmp++;
      if (obs !== expv) begin n_bad++; $display("[TB] FAIL simul_release c=%0d got %b want %b", c, obs, expv); end
    end
  endtask

  task automatic test_reset_mid_check();
    key_in = 4'b1011;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (obs !== '0) begin n_bad++; $display("[TB] FAIL midreset_async got %b want 0", obs); end
    @(negedge clock);
    reset = 1'b0;
    for (int e = 0; e < 7; e++) begin
      @(negedge clock);
      n_cmp++;
      if (obs !== expv) begin n_bad++; $display("[TB] FAIL midreset_model e=%0d got %b want %b", e, obs, expv); end
      if (e == 4 || e == 5) begin
        n_cmp++;
        if (key_press[2] !== ((e == 5) ? 1'b1 : 1'b0)) begin
          n_bad++; $display("[TB] FAIL midreset_press e=%0d got %b want %b", e, key_press[2], e == 5);
        end
      end
    end
    key_in = '1;
    repeat (SC + 4) @(negedge clock);
  endtask

  task automatic test_random();
    int hold [NK];
    for (int i = 0; i < NK; i++) hold[i] = 1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NK; i++) begin
        hold[i]--;
        if (hold[i] == 0) begin
          key_in[i] = ~key_in[i];
          hold[i]   = int'($urandom_range(1, 9));
        end
      end
      @(negedge clock);
      n_cmp++;
      if (obs !== expv || (key_press & key_release) !== '0) begin
        n_bad++; $display("[TB] FAIL random_model c=%0d got %b want %b", c, obs, expv);
      end
    end
    key_in = '1;
    for (int c = 0; c < SC + 4; c++) begin
      @(negedge clock);
      n_cmp++;
      if (obs !== expv) begin n_bad++; $display("[TB] FAIL random_settle c=%0d got %b want %b", c, obs, expv); end
    end
  endtask

`ifdef KEY_DEBOUNCE_REPEAT_EN
  task automatic test_repeat();
    int pulses = 0;
    key_in = 4'b1110;
    for (int c = 0; c < 44; c++) begin
      if (c == 30) key_in = '1;
      @(negedge clock);
      pulses += int'(key_press[0]);
      n_cmp++;
      if (obs !== expv) begin n_bad++; $display("[TB] FAIL repeat_model c=%0d got %b want %b", c, obs, expv); end
    end
    n_cmp++;
    if (pulses != 6) begin n_bad++; $display("[TB] FAIL repeat_pulses got %0d want 6", pulses); end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid_check();
    test_random();
`ifdef KEY_DEBOUNCE_REPEAT_EN
    test_repeat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_debounce_array.md
# key_debounce_array

Parametrised multi-channel push-button debouncer between the board's raw active-low keys and the game control logic. Each channel has its own synchroniser, stability counter and small state machine. Each channel produces a clean debounced level plus one-cycle press and release pulses. An optional compile-time auto-repeat generates repeated press pulses while a key is held.

## Interface
Parameters:
- NUM_KEYS, 4, number of independent key channels (≥1)
- STABLE_CYCLES, 16, consecutive differing samples required to change debounced level (≥2)
- ACTIVE_LOW, 1, 1: raw key reads 0 when pressed; 0: raw key reads 1 when pressed
- REPEAT_DELAY, 500000, cycles from press pulse to first repeat pulse (used only with KEY_DEBOUNCE_REPEAT_EN, ≥1)
- REPEAT_PERIOD, 100000, cycles between subsequent repeat pulses (used only with KEY_DEBOUNCE_REPEAT_EN, ≥1)

Ports:
- clock  input  1  system clock; one clock, all state on its rising edge
- reset  input  1  asynchronous, active-high reset
- key_in  input  NUM_KEYS  raw asynchronous key inputs, polarity per ACTIVE_LOW
- key_level  output  NUM_KEYS  debounced level, 1 = pressed
- key_press  output  NUM_KEYS  one-cycle pulse on debounced press (and on repeats)
- key_release  output  NUM_KEYS  one-cycle pulse on debounced release
- any_pressed  output  1  OR of key_level

## Operation
- Per channel: 2-flop synchroniser → polarity normalisation (pressed = 1) → sample s.
- Per-channel states: RELEASED, PRESS_CHECK, PRESSED, RELEASE_CHECK.
- RELEASED: s=1 → PRESS_CHECK, count=1.
- PRESS_CHECK: s=0 → RELEASED, count=0.
  - s=1 with count<STABLE_CYCLES-1 → count+1.
  - s=1 with count=STABLE_CYCLES-1 → PRESSED, key_level=1, key_press pulse, count=0.
- PRESSED and RELEASE_CHECK mirror RELEASED and PRESS_CHECK with s inverted. Completing the release check gives key_level=0 and a key_release pulse.
- Any single contrary sample during a check aborts it. The count restarts from zero on the next differing sample.
- Counter width: $clog2(STABLE_CYCLES). Counter never wraps and saturates at threshold.
- Channels are fully independent. Simultaneous pulses on several channels in the same cycle are legal and all reported.
- any_pressed is the combinational OR of the registered key_level bits.

## Timing
- Edge 0 is the first edge sampling a new stable key_in value. key_level updates at edge STABLE_CYCLES+1. The pulse asserts on that same edge.
- key_press and key_release are high for exactly one cycle and never overlap on a channel.
- Reset, asynchronous:
  - Synchroniser flops load the released value; state=RELEASED; counters=0.
  - key_level=0, key_press=0, key_release=0, any_pressed=0.
- Key held through reset: treated as a new press after deassertion, with a press pulse at edge STABLE_CYCLES+1.
- Reset asserted mid-check or mid-repeat: all progress discarded, no pulse emitted.

## Configuration
- Macro KEY_DEBOUNCE_REPEAT_EN.
- Defined:
  - In PRESSED, a per-channel repeat counter runs from the initial press pulse.
  - key_press re-pulses REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles.
  - In RELEASE_CHECK the repeat counter holds and pulses are suppressed. It resumes if the check aborts, and clears on entering RELEASED.
- Undefined: exactly one key_press per debounced press; REPEAT_* parameters ignored; no repeat counters synthesised.

## Structure
- Shared package key_pkg: state enum typedef (RELEASED, PRESS_CHECK, PRESSED, RELEASE_CHECK) and default constants for STABLE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD.
- Sub-module key_debounce_channel: synchroniser, counter, FSM and optional repeat logic for one key.
- Top level generates NUM_KEYS instances and the any_pressed OR.

## Test plan
- Clean press, STABLE_CYCLES=4, ACTIVE_LOW=1: key_in[0] 1→0 before edge 0 → key_level[0]=1 and key_press[0]=1 after edge 5; key_press[0]=0 after edge 6; any_pressed=1.
- Bounce: key_in[1] low for 3 cycles, high 1, then low steady → no pulse until 4 consecutive low samples; exactly one key_press[1].
- Release: key_in[0] 0→1 steady → key_release[0] one cycle at edge 5, key_level[0]=0, any_pressed=0 when no other key is held.
- Simultaneous: key_in[3:0]=4'b0000 in the same cycle → key_press=4'b1111 for one cycle.
- Reset mid-check: reset pulse at edge 3 of a press → all outputs 0; key still low → press pulse 5 edges after reset deasserts.
- Repeat (KEY_DEBOUNCE_REPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=4): hold key 30 cycles → pulses at press+0, +10, +14, +18, +22, +26; none after release.
